// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: one debounced press -> 4-bit hex key_code + one-cycle key_valid.
// Latency: 2-flop row sync, then DEBOUNCE_CNT clks from detect to key_valid; no backpressure, pulse is fire-and-forget.
module keypad_scanner #(
  parameter int SCAN_DIV     = 48000,
  parameter int DEBOUNCE_CNT = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam logic [SW-1:0] DWELL_LAST    = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DWELL_SETTLED = SW'(2);
  localparam logic [DW-1:0] DB_LAST       = DW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state;
  logic [3:0]    sync1;
  logic [3:0]    rs;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [SW-1:0] dwell;
  logic [DW-1:0] cnt;
  logic [1:0]    low_row;
  logic          any_low;
  logic          row_low;

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    col_drive = ~(4'b0001 << c);
  endfunction

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: keymap = 4'h1;
      4'h1: keymap = 4'h2;
      4'h2: keymap = 4'h3;
      4'h3: keymap = 4'hA;
      4'h4: keymap = 4'h4;
      4'h5: keymap = 4'h5;
      4'h6: keymap = 4'h6;
      4'h7: keymap = 4'hB;
      4'h8: keymap = 4'h7;
      4'h9: keymap = 4'h8;
      4'hA: keymap = 4'h9;
      4'hB: keymap = 4'hC;
      4'hC: keymap = 4'hE;
      4'hD: keymap = 4'h0;
      4'hE: keymap = 4'hF;
      default: keymap = 4'hD;
    endcase
  endfunction

  // Lowest row index wins when several rows are low at detect time.
  always_comb begin
    any_low = (rs != 4'hF);
    if (!rs[0])      low_row = 2'd0;
    else if (!rs[1]) low_row = 2'd1;
    else if (!rs[2]) low_row = 2'd2;
    else             low_row = 2'd3;
  end

  assign row_low = ~rs[row_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      sync1     <= 4'hF;
      rs        <= 4'hF;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      cols      <= 4'b1110;
      dwell     <= '0;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      sync1     <= rows;
      rs        <= sync1;
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          // Detect waits for dwell>=2 so rs reflects the column now driven.
          if (dwell >= DWELL_SETTLED && any_low) begin
            row_idx <= low_row;
            state   <= DEBOUNCE;
            cnt     <= '0;
            dwell   <= '0;
          end else if (dwell == DWELL_LAST) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            cols    <= col_drive(col_idx + 2'd1);
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!row_low) begin
            state <= SCAN;
            dwell <= '0;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            key_code  <= keymap(row_idx, col_idx);
            key_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!row_low) begin
            state <= RELEASE;
            cnt   <= '0;
          end
        end
        RELEASE: begin
          if (row_low) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state   <= SCAN;
            cnt     <= '0;
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            cols    <= col_drive(col_idx + 2'd1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
